// File: rtl/stopwatch_sequencer.sv
// Stopwatch front-end: button synchronize/debounce plus run-control FSM.
// Optional auto-stop on datapath max is enabled by defining STOPWATCH_AUTO_STOP_EN.
//
// state | meaning
// IDLE  | cleared, not counting
// RUN   | counting, display live
// LAP   | counting, display frozen
// STOP  | halted, display live
module stopwatch_sequencer #(
   parameter int DB_CYCLES = 2,
   parameter int LAP_MAX   = 9
) (
   input  logic       clk_100hz,
   input  logic       rst,
   input  logic       btn_start,
   input  logic       btn_lap,
   input  logic       at_max,
   output logic       sw_en,
   output logic       pause,
   output logic       clear,
   output logic [1:0] state,
   output logic [3:0] lap_cnt,
   output logic       overflow
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      LAP  = 2'd2,
      STOP = 2'd3
   } state_t;

   localparam logic [3:0] DB_LAST = 4'(DB_CYCLES - 1);
   localparam logic [3:0] LAP_TOP = 4'(LAP_MAX);

   // bit 0 = start/stop button, bit 1 = lap/reset button
   logic [1:0] sync1_q, sync1_d;
   logic [1:0] sync2_q, sync2_d;
   logic [1:0] db_q, db_d;
   logic [1:0] db_prev_q, db_prev_d;
   logic [3:0] cnt_q [2];
   logic [3:0] cnt_d [2];
   logic [1:0] evt;
   logic       start_evt;
   logic       lap_evt;

   state_t     state_q, state_d;
   logic       sw_en_q, sw_en_d;
   logic       pause_q, pause_d;
   logic       clear_q, clear_d;
   logic [3:0] lap_cnt_q, lap_cnt_d;
   logic       auto_stop;
   logic       start_blocked;

   always_comb begin
      sync1_d   = {btn_lap, btn_start};
      sync2_d   = sync1_q;
      db_prev_d = db_q;
      db_d      = db_q;
      for (int i = 0; i < 2; i++) begin
         cnt_d[i] = 4'd0;
         if (sync2_q[i] != db_q[i]) begin
            if (cnt_q[i] == DB_LAST) begin
               db_d[i] = sync2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + 4'd1;
            end
         end
      end
   end

   assign evt       = db_q & ~db_prev_q;
   assign start_evt = evt[0];
   assign lap_evt   = evt[1];

   always_ff @(posedge clk_100hz or posedge rst) begin
      if (rst) begin
         sync1_q   <= 2'b00;
         sync2_q   <= 2'b00;
         db_q      <= 2'b00;
         db_prev_q <= 2'b00;
         cnt_q[0]  <= 4'd0;
         cnt_q[1]  <= 4'd0;
      end else begin
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         db_q      <= db_d;
         db_prev_q <= db_prev_d;
         cnt_q[0]  <= cnt_d[0];
         cnt_q[1]  <= cnt_d[1];
      end
   end

`ifdef STOPWATCH_AUTO_STOP_EN
   logic overflow_q, overflow_d;

   assign auto_stop     = at_max && ((state_q == RUN) || (state_q == LAP));
   assign start_blocked = overflow_q;
   assign overflow      = overflow_q;

   always_ff @(posedge clk_100hz or posedge rst) begin
      if (rst) overflow_q <= 1'b0;
      else     overflow_q <= overflow_d;
   end
`else
   logic unused_at_max;

   assign unused_at_max = at_max;
   assign auto_stop     = 1'b0;
   assign start_blocked = 1'b0;
   assign overflow      = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      lap_cnt_d = lap_cnt_q;
      clear_d   = 1'b0;
`ifdef STOPWATCH_AUTO_STOP_EN
      overflow_d = overflow_q;
`endif
      case (state_q)
         IDLE: begin
            if (start_evt) begin
               state_d = RUN;
            end else if (lap_evt) begin
               clear_d   = 1'b1;
               lap_cnt_d = 4'd0;
            end
         end
         RUN: begin
            if (auto_stop) begin
               state_d = STOP;
`ifdef STOPWATCH_AUTO_STOP_EN
               overflow_d = 1'b1;
`endif
            end else if (start_evt) begin
               state_d = STOP;
            end else if (lap_evt) begin
               state_d   = LAP;
               lap_cnt_d = (lap_cnt_q >= LAP_TOP) ? lap_cnt_q : lap_cnt_q + 4'd1;
            end
         end
         LAP: begin
            if (auto_stop) begin
               state_d = STOP;
`ifdef STOPWATCH_AUTO_STOP_EN
               overflow_d = 1'b1;
`endif
            end else if (start_evt) begin
               state_d = STOP;
            end else if (lap_evt) begin
               state_d = RUN;
            end
         end
         STOP: begin
            // after an auto-stop only the clear path may leave STOP
            if (start_evt && !start_blocked) begin
               state_d = RUN;
            end else if (lap_evt) begin
               state_d   = IDLE;
               clear_d   = 1'b1;
               lap_cnt_d = 4'd0;
`ifdef STOPWATCH_AUTO_STOP_EN
               overflow_d = 1'b0;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
      sw_en_d = (state_d == RUN) || (state_d == LAP);
      pause_d = (state_d == LAP);
   end

   always_ff @(posedge clk_100hz or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         sw_en_q   <= 1'b0;
         pause_q   <= 1'b0;
         clear_q   <= 1'b0;
         lap_cnt_q <= 4'd0;
      end else begin
         state_q   <= state_d;
         sw_en_q   <= sw_en_d;
         pause_q   <= pause_d;
         clear_q   <= clear_d;
         lap_cnt_q <= lap_cnt_d;
      end
   end

   assign state   = state_q;
   assign sw_en   = sw_en_q;
   assign pause   = pause_q;
   assign clear   = clear_q;
   assign lap_cnt = lap_cnt_q;

endmodule

// File: tb/tb_stopwatch_sequencer.sv
// Directed bench for stopwatch_sequencer (DB_CYCLES=2, LAP_MAX=2).
module tb_stopwatch_sequencer;

   logic       clk_100hz = 1'b0;
   logic       rst       = 1'b1;
   logic       btn_start = 1'b0;
   logic       btn_lap   = 1'b0;
   logic       at_max    = 1'b0;
   logic       sw_en;
   logic       pause;
   logic       clear;
   logic [1:0] state;
   logic [3:0] lap_cnt;
   logic       overflow;

   int n_checks = 0;
   int n_pass   = 0;

   stopwatch_sequencer #(.DB_CYCLES(2), .LAP_MAX(2)) dut (
      .clk_100hz (clk_100hz),
      .rst       (rst),
      .btn_start (btn_start),
      .btn_lap   (btn_lap),
      .at_max    (at_max),
      .sw_en     (sw_en),
      .pause     (pause),
      .clear     (clear),
      .state     (state),
      .lap_cnt   (lap_cnt),
      .overflow  (overflow)
   );

   always #5 clk_100hz = ~clk_100hz;

   typedef struct {
      logic       s;
      logic       l;
      logic [1:0] st;
      logic       sw;
      logic       p;
      logic       clr;
      logic [3:0] lap;
      string      nm;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(input logic s, input logic l, input logic [1:0] st,
                               input logic sw, input logic p, input logic clr,
                               input logic [3:0] lap, input string nm);
      vec_t v;
      v.s = s; v.l = l; v.st = st; v.sw = sw; v.p = p; v.clr = clr; v.lap = lap; v.nm = nm;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic chk_all(input string nm, input logic [1:0] st, input logic sw,
                          input logic p, input logic clr, input logic [3:0] lap,
                          input logic ovf);
      chk({nm, ".state"},    32'(state),    32'(st));
      chk({nm, ".sw_en"},    32'(sw_en),    32'(sw));
      chk({nm, ".pause"},    32'(pause),    32'(p));
      chk({nm, ".clear"},    32'(clear),    32'(clr));
      chk({nm, ".lap_cnt"},  32'(lap_cnt),  32'(lap));
      chk({nm, ".overflow"}, 32'(overflow), 32'(ovf));
   endtask

   // Raw press before edge 1; evt after edge 4; outputs sampled after edge 5.
   task automatic press(input logic s, input logic l, input logic am);
      @(negedge clk_100hz);
      btn_start = s;
      btn_lap   = l;
      repeat (4) @(posedge clk_100hz);
      #1 at_max = am;
      @(posedge clk_100hz);
      #1;
   endtask

   task automatic release_btns(input string nm);
      @(posedge clk_100hz);
      #1 chk({nm, ".clear_gone"}, 32'(clear), 32'd0);
      at_max = 1'b0;
      @(negedge clk_100hz);
      btn_start = 1'b0;
      btn_lap   = 1'b0;
      repeat (6) @(negedge clk_100hz);
   endtask

   initial begin
      // 1: reset state, then btn_start held through reset release
      btn_start = 1'b1;
      repeat (3) @(negedge clk_100hz);
      chk_all("reset", 2'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
      rst = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         @(posedge clk_100hz);
         #1;
         if (k == 4) begin
            chk("held_e4.state", 32'(state), 32'd0);
            chk("held_e4.sw_en", 32'(sw_en), 32'd0);
         end
      end
      chk_all("held_e5", 2'd1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
      @(negedge clk_100hz);
      btn_start = 1'b0;
      repeat (6) @(negedge clk_100hz);

      // mid-operation reset stops counting immediately
      @(posedge clk_100hz);
      #3 rst = 1'b1;
      #1 chk_all("mid_rst", 2'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
      @(negedge clk_100hz);
      rst = 1'b0;
      repeat (2) @(negedge clk_100hz);

      // 2: one-sample start glitch, then 2-sample lap press in IDLE
      btn_start = 1'b1;
      @(negedge clk_100hz);
      btn_start = 1'b0;
      repeat (6) @(negedge clk_100hz);
      chk("glitch.state", 32'(state), 32'd0);
      chk("glitch.sw_en", 32'(sw_en), 32'd0);
      btn_lap = 1'b1;
      repeat (2) @(posedge clk_100hz);
      @(negedge clk_100hz);
      btn_lap = 1'b0;
      for (int k = 3; k <= 8; k++) begin
         @(posedge clk_100hz);
         #1;
         chk($sformatf("short_lap_e%0d.clear", k), 32'(clear), (k == 5) ? 32'd1 : 32'd0);
         chk($sformatf("short_lap_e%0d.state", k), 32'(state), 32'd0);
      end
      chk("short_lap.lap_cnt", 32'(lap_cnt), 32'd0);
      repeat (4) @(negedge clk_100hz);

      // 3/4/5: table of press events, LAP_MAX=2
      vq.push_back(mk(1, 0, 2'd1, 1, 0, 0, 4'd0, "v_start_run"));
      vq.push_back(mk(0, 1, 2'd2, 1, 1, 0, 4'd1, "v_lap1"));
      vq.push_back(mk(0, 1, 2'd1, 1, 0, 0, 4'd1, "v_lap_back"));
      vq.push_back(mk(0, 1, 2'd2, 1, 1, 0, 4'd2, "v_lap2"));
      vq.push_back(mk(0, 1, 2'd1, 1, 0, 0, 4'd2, "v_lap_back2"));
      vq.push_back(mk(0, 1, 2'd2, 1, 1, 0, 4'd2, "v_lap_sat"));
      vq.push_back(mk(1, 0, 2'd3, 0, 0, 0, 4'd2, "v_lap_stop"));
      vq.push_back(mk(1, 0, 2'd1, 1, 0, 0, 4'd2, "v_resume"));
      vq.push_back(mk(1, 1, 2'd3, 0, 0, 0, 4'd2, "v_both_run"));
      vq.push_back(mk(0, 1, 2'd0, 0, 0, 1, 4'd0, "v_stop_clear"));
      vq.push_back(mk(1, 0, 2'd1, 1, 0, 0, 4'd0, "v_restart"));
      vq.push_back(mk(1, 0, 2'd3, 0, 0, 0, 4'd0, "v_stop2"));
      vq.push_back(mk(0, 1, 2'd0, 0, 0, 1, 4'd0, "v_clear2"));
      vq.push_back(mk(0, 1, 2'd0, 0, 0, 1, 4'd0, "v_idle_clear"));
      vq.push_back(mk(1, 1, 2'd1, 1, 0, 0, 4'd0, "v_both_idle"));
      vq.push_back(mk(0, 1, 2'd2, 1, 1, 0, 4'd1, "v_lap3"));
      vq.push_back(mk(1, 1, 2'd3, 0, 0, 0, 4'd1, "v_both_lap"));
      vq.push_back(mk(0, 1, 2'd0, 0, 0, 1, 4'd0, "v_clear3"));
      for (int i = 0; i < vq.size(); i++) begin
         press(vq[i].s, vq[i].l, 1'b0);
         chk_all(vq[i].nm, vq[i].st, vq[i].sw, vq[i].p, vq[i].clr, vq[i].lap, 1'b0);
         release_btns(vq[i].nm);
      end

      // 6: at_max together with lap_evt while in LAP
      press(1, 0, 0);
      release_btns("am_start");
      press(0, 1, 0);
      chk_all("am_lap", 2'd2, 1'b1, 1'b1, 1'b0, 4'd1, 1'b0);
      release_btns("am_lap");
      press(0, 1, 1);
`ifdef STOPWATCH_AUTO_STOP_EN
      chk_all("am_hit", 2'd3, 1'b0, 1'b0, 1'b0, 4'd1, 1'b1);
`else
      chk_all("am_hit", 2'd1, 1'b1, 1'b0, 1'b0, 4'd1, 1'b0);
`endif
      release_btns("am_hit");
      press(1, 0, 0);
`ifdef STOPWATCH_AUTO_STOP_EN
      chk_all("am_start_ign", 2'd3, 1'b0, 1'b0, 1'b0, 4'd1, 1'b1);
`else
      chk_all("am_start_ign", 2'd3, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0);
`endif
      release_btns("am_start_ign");
      press(0, 1, 0);
      chk_all("am_clear", 2'd0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0);
      release_btns("am_clear");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
